fir_controller: RTL

//   Sequencer for the 64-tap MAC FIR datapath. Accepts one input sample per valid/ready

---
 rtl/fir_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fir_controller.sv
// Sequencer for the MAC FIR datapath: accepts a sample, sweeps tap addresses,
// and times accumulator clear/enable and the output-valid strobe.
module fir_controller #(
  parameter int TAPS     = 64,
  parameter int ADDR_W   = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_valid,
  output logic              input_ready,
  output logic              new_input,
  output logic [ADDR_W-1:0] address,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              output_valid,
  output logic              overrun
);

  localparam int CW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, MAC, DRAIN, DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       cnt_q;
  logic                rdy_q;
  logic                new_q;
  logic                clr_q;
  logic                tv_q;
  logic                ov_q;
  logic                ovr_q;
  logic                ovr_d;
  logic [PIPE_LAT-1:0] dl_q;
  logic [PIPE_LAT-1:0] dl_d;

  // tap_valid delayed by the multiply pipeline depth
  always_comb begin
    dl_d    = '0;
    dl_d[0] = tv_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  assign ovr_d = ovr_q | (input_valid & ~rdy_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      new_q   <= 1'b0;
      clr_q   <= 1'b0;
      tv_q    <= 1'b0;
      ov_q    <= 1'b0;
      ovr_q   <= 1'b0;
      dl_q    <= '0;
    end else begin
      ovr_q <= ovr_d;
      dl_q  <= dl_d;
      unique case (state_q)
        IDLE: begin
          if (input_valid) begin
            state_q <= SHIFT;
            rdy_q   <= 1'b0;
            new_q   <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        SHIFT: begin
          state_q <= MAC;
          new_q   <= 1'b0;
          clr_q   <= 1'b0;
          tv_q    <= 1'b1;
          addr_q  <= '0;
        end
        MAC: begin
          if (addr_q == ADDR_W'(TAPS - 1)) begin
            state_q <= DRAIN;
            tv_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CW'(PIPE_LAT - 1)) begin
            state_q <= DONE;
            ov_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ov_q    <= 1'b0;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          rdy_q   <= 1'b1;
          new_q   <= 1'b0;
          clr_q   <= 1'b0;
          tv_q    <= 1'b0;
          ov_q    <= 1'b0;
        end
      endcase
    end
  end

  assign input_ready  = rdy_q;
  assign new_input    = new_q;
  assign address      = addr_q;
  assign acc_clr      = clr_q;
  assign acc_en       = dl_q[PIPE_LAT-1];
  assign output_valid = ov_q;
  assign overrun      = ovr_q;

endmodule
